// File: rtl/seg7_frame_decoder.sv
// Serial seven-segment frame decoder.
// Shifts in an 8-bit {dp,g,f,e,d,c,b,a} frame under sen, decodes the segment
// pattern to a hex digit and presents it until the consumer acknowledges.
module seg7_frame_decoder (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {StIdle, StShift, StDecode, StResult} state_e;

  logic clk;
  logic rst_n;
  logic sdata;
  logic sen;
  logic ack;
  logic unused_in;

  assign clk       = io_in[0];
  assign rst_n     = io_in[1];
  assign sdata     = io_in[2];
  assign sen       = io_in[3];
  assign ack       = io_in[4];
  assign unused_in = ^io_in[7:5];

  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sen_q;
  logic [3:0] digit_q, digit_d;
  logic       err_q, err_d;
  logic       dp_q, dp_d;

  logic       frame_start;
  logic [3:0] dec_digit;
  logic       dec_hit;
  logic       valid;
  logic       busy;

  // Only meaningful in StIdle; sen held high across RESULT->IDLE sees sen_q=1.
  assign frame_start = sen & ~sen_q;

  // Segment pattern lookup on the seven segment bits.
  always_comb begin
    dec_digit = 4'h0;
    dec_hit   = 1'b1;
    case (sr_q[6:0])
      7'h3F:   dec_digit = 4'h0;
      7'h06:   dec_digit = 4'h1;
      7'h5B:   dec_digit = 4'h2;
      7'h4F:   dec_digit = 4'h3;
      7'h66:   dec_digit = 4'h4;
      7'h6D:   dec_digit = 4'h5;
      7'h7D:   dec_digit = 4'h6;
      7'h07:   dec_digit = 4'h7;
      7'h7F:   dec_digit = 4'h8;
      7'h6F:   dec_digit = 4'h9;
      7'h77:   dec_digit = 4'hA;
      7'h7C:   dec_digit = 4'hB;
      7'h39:   dec_digit = 4'hC;
      7'h5E:   dec_digit = 4'hD;
      7'h79:   dec_digit = 4'hE;
      7'h71:   dec_digit = 4'hF;
      default: begin
        dec_digit = 4'h0;
        dec_hit   = 1'b0;
      end
    endcase
  end

  // Next-state logic for the FSM, shift register, counter and result fields.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    err_d   = err_q;
    dp_d    = dp_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          sr_d    = {7'b0, sdata};
          cnt_d   = 4'd1;
          err_d   = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (sen) begin
          sr_d  = {sr_q[6:0], sdata};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_d = StDecode;
          end
        end else begin
          // Frame dropped early: flag it and throw away the partial bits.
          err_d   = 1'b1;
          sr_d    = 8'h00;
          cnt_d   = 4'd0;
          state_d = StIdle;
        end
      end
      StDecode: begin
        digit_d = dec_digit;
        err_d   = ~dec_hit;
        dp_d    = sr_q[7];
        cnt_d   = 4'd0;
        state_d = StResult;
      end
      StResult: begin
        if (ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sr_q    <= 8'h00;
      cnt_q   <= 4'd0;
      sen_q   <= 1'b0;
      digit_q <= 4'h0;
      err_q   <= 1'b0;
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      sen_q   <= sen;
      digit_q <= digit_d;
      err_q   <= err_d;
      dp_q    <= dp_d;
    end
  end

  assign valid  = (state_q == StResult);
  assign busy   = (state_q == StShift) || (state_q == StDecode);
  assign io_out = {busy, dp_q, err_q, valid, digit_q};

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Self-checking bench for seg7_frame_decoder using an expected-result queue.
module tb_seg7_frame_decoder;

  typedef struct packed {
    logic [3:0] digit;
    logic       err;
    logic       dp;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       sdata = 1'b0;
  logic       sen   = 1'b0;
  logic       ack   = 1'b0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  logic [3:0] last_digit = 4'h0;
  logic       last_dp    = 1'b0;
  logic [6:0] seg_tab [16];

  assign io_in = {3'b000, ack, sen, sdata, rst_n, clk};

  seg7_frame_decoder dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [7:0] f);
    exp_t e;
    e.digit = 4'h0;
    e.err   = 1'b1;
    e.dp    = f[7];
    for (int k = 0; k < 16; k++) begin
      if (seg_tab[k] == f[6:0]) begin
        e.digit = k[3:0];
        e.err   = 1'b0;
      end
    end
    return e;
  endfunction

  // Drive a full 8-bit frame; leaves the DUT in its decode cycle.
  task automatic send_frame(input logic [7:0] f);
    sen = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      sdata = f[i];
      tick();
      total++;
      if (io_out[7] !== 1'b1) begin
        bad++;
        $display("FAIL shift_busy bit=%0d got=%b want=1", i, io_out[7]);
      end
      if (i == 7) begin
        total++;
        if (io_out[5] !== 1'b0) begin
          bad++;
          $display("FAIL err_clear_at_start got=%b want=0", io_out[5]);
        end
      end
    end
    sen   = 1'b0;
    sdata = 1'b0;
    total++;
    if (io_out[4] !== 1'b0) begin
      bad++;
      $display("FAIL decode_valid got=%b want=0", io_out[4]);
    end
    sb.push_back(model(f));
  endtask

  // Wait for valid, check against the queue, hold for ack_delay clocks, then ack.
  task automatic wait_result(input int ack_delay);
    int n;
    exp_t e;
    logic [7:0] exp_out;
    n = 0;
    tick();
    while (io_out[4] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL latency extra_clocks=%0d want=0", n);
    end
    if (io_out[4] === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result got=%h want=none", io_out);
      end else begin
        e       = sb.pop_front();
        exp_out = {1'b0, e.dp, e.err, 1'b1, e.digit};
        if (io_out !== exp_out) begin
          bad++;
          $display("FAIL result got=%h want=%h", io_out, exp_out);
        end
        for (int d = 0; d < ack_delay; d++) begin
          tick();
          total++;
          if (io_out !== exp_out) begin
            bad++;
            $display("FAIL result_hold cyc=%0d got=%h want=%h", d, io_out, exp_out);
          end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++;
        if (io_out !== (exp_out & 8'h6F)) begin
          bad++;
          $display("FAIL after_ack got=%h want=%h", io_out, exp_out & 8'h6F);
        end
        last_digit = e.digit;
        last_dp    = e.dp;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (io_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_async got=%h want=00", io_out);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (io_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_idle got=%h want=00", io_out);
    end
  endtask

  task automatic test_basic();
    send_frame(8'h5B);
    wait_result(3);
  endtask

  task automatic test_back_to_back();
    send_frame(8'hFF);
    wait_result(0);
    send_frame(8'h71);
    wait_result(1);
  endtask

  task automatic test_bad_pattern();
    send_frame(8'h12);
    wait_result(1);
  endtask

  task automatic test_framing();
    logic [7:0] exp_out;
    sen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sdata = i[0];
      tick();
    end
    total++;
    if (io_out[7] !== 1'b1) begin
      bad++;
      $display("FAIL partial_busy got=%b want=1", io_out[7]);
    end
    sen   = 1'b0;
    sdata = 1'b0;
    tick();
    exp_out = {1'b0, last_dp, 1'b1, 1'b0, last_digit};
    for (int c = 0; c < 3; c++) begin
      total++;
      if (io_out !== exp_out) begin
        bad++;
        $display("FAIL framing_err cyc=%0d got=%h want=%h", c, io_out, exp_out);
      end
      tick();
    end
    send_frame(8'h06);
    wait_result(0);
  endtask

  task automatic test_sen_held();
    logic [7:0] f;
    logic [7:0] seen;
    logic [7:0] exp_out;
    int vcount;
    int busy_late;
    exp_t e;
    f         = 8'h4F;
    seen      = 8'h00;
    vcount    = 0;
    busy_late = 0;
    sb.push_back(model(f));
    ack = 1'b1;
    sen = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c < 8) sdata = f[7-c];
      else sdata = 1'b0;
      if (c == 12) sen = 1'b0;
      tick();
      if (io_out[4] === 1'b1) begin
        vcount++;
        seen = io_out;
      end
      if (c >= 9 && io_out[7] !== 1'b0) busy_late++;
    end
    ack = 1'b0;
    total++;
    if (vcount != 1) begin
      bad++;
      $display("FAIL held_valid_cycles got=%0d want=1", vcount);
    end
    total++;
    if (busy_late != 0) begin
      bad++;
      $display("FAIL held_restart busy_cycles=%0d want=0", busy_late);
    end
    if (sb.size() != 0) begin
      e       = sb.pop_front();
      exp_out = {1'b0, e.dp, e.err, 1'b1, e.digit};
      total++;
      if (seen !== exp_out) begin
        bad++;
        $display("FAIL held_result got=%h want=%h", seen, exp_out);
      end
      last_digit = e.digit;
      last_dp    = e.dp;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] f;
    exp_t e;
    logic [7:0] exp_out;
    f   = 8'h6D;
    sen = 1'b1;
    for (int i = 7; i >= 4; i--) begin
      sdata = f[i];
      tick();
    end
    total++;
    if (io_out[7] !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy got=%b want=1", io_out[7]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (io_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_midframe got=%h want=00", io_out);
    end
    sen   = 1'b0;
    sdata = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (io_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_idle got=%h want=00", io_out);
    end
    send_frame(f);
    tick();
    e       = sb.pop_front();
    exp_out = {1'b0, e.dp, e.err, 1'b1, e.digit};
    total++;
    if (io_out !== exp_out) begin
      bad++;
      $display("FAIL pre_reset_result got=%h want=%h", io_out, exp_out);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (io_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_result got=%h want=00", io_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(f);
    wait_result(1);
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    test_reset();
    test_basic();
    test_back_to_back();
    test_framing();
    test_bad_pattern();
    test_sen_held();
    tick();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover_results got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
